timer_counter_core: RTL and testbench

Main count and compare stage of the timer. Consumes the single-cycle `cnt_en` tick from the prescaler and advances a 64-bit up-counter. Compares the count against a 64-bit compare value and raises a sticky interrupt on match. Register-file writes reach the counter and compare halves directly; the block drives the timer interrupt line.

---
 rtl/timer_counter_core.sv | 84 ++++++++
 tb/tb_timer_counter_core.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter_core.sv
// 64-bit timer count/compare stage: counts prescaler ticks, compares against a
// 64-bit compare register and raises a sticky interrupt on match.
module timer_counter_core #(
   parameter logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        timer_en,
   input  logic        cnt_en,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        cnt_lo_wr,
   input  logic        cnt_hi_wr,
   input  logic        cmp_lo_wr,
   input  logic        cmp_hi_wr,
   input  logic        int_clr,
   input  logic        int_en,
   output logic [63:0] cnt,
   output logic [63:0] cmp,
   output logic        int_st,
   output logic        tim_int
);

   logic [63:0] r_cnt;
   logic [63:0] r_cmp;
   logic        r_int_st;
   logic        r_timer_en_d;

   logic        w_match;
   logic        w_cnt_wr;
   logic        w_en_fall;

   // Byte-strobed merge of write data into one 32-bit half.
   function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                           input logic [31:0] wd,
                                           input logic [3:0]  st);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (st[i]) res[8*i +: 8] = wd[8*i +: 8];
      end
      return res;
   endfunction

   assign w_match   = (r_cnt == r_cmp);
   assign w_cnt_wr  = cnt_lo_wr | cnt_hi_wr;
   assign w_en_fall = r_timer_en_d & ~timer_en;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // branch reads the pre-edge values of r_cnt/r_cmp regardless of order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_cmp        <= CMP_RST;
         r_int_st     <= 1'b0;
         r_timer_en_d <= 1'b0;
      end else begin
         r_timer_en_d <= timer_en;

         // Register writes beat the disable clear, which beats the tick.
         if (w_cnt_wr) begin
            if (cnt_lo_wr) r_cnt[31:0]  <= f_merge(r_cnt[31:0],  wdata, wstrb);
            if (cnt_hi_wr) r_cnt[63:32] <= f_merge(r_cnt[63:32], wdata, wstrb);
         end else if (w_en_fall) begin
            r_cnt <= '0;
         end else if (cnt_en) begin
            r_cnt <= r_cnt + 64'd1;
         end

         if (cmp_lo_wr) r_cmp[31:0]  <= f_merge(r_cmp[31:0],  wdata, wstrb);
         if (cmp_hi_wr) r_cmp[63:32] <= f_merge(r_cmp[63:32], wdata, wstrb);

         // A live match holds the status set even against a clear request.
         if (w_match)      r_int_st <= 1'b1;
         else if (int_clr) r_int_st <= 1'b0;
      end
   end

   assign cnt     = r_cnt;
   assign cmp     = r_cmp;
   assign int_st  = r_int_st;
   assign tim_int = r_int_st & int_en;

endmodule

// File: tb/tb_timer_counter_core.sv
// Self-checking bench for timer_counter_core: per-cycle comparison against a
// spec-level model plus hand-computed checkpoints from the directed sequence.
module tb_timer_counter_core;

   localparam logic [63:0] CMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        timer_en;
   logic        cnt_en;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        cnt_lo_wr;
   logic        cnt_hi_wr;
   logic        cmp_lo_wr;
   logic        cmp_hi_wr;
   logic        int_clr;
   logic        int_en;
   logic [63:0] cnt;
   logic [63:0] cmp;
   logic        int_st;
   logic        tim_int;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   timer_counter_core #(.CMP_RST(CMP_RST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .timer_en  (timer_en),
      .cnt_en    (cnt_en),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .cnt_lo_wr (cnt_lo_wr),
      .cnt_hi_wr (cnt_hi_wr),
      .cmp_lo_wr (cmp_lo_wr),
      .cmp_hi_wr (cmp_hi_wr),
      .int_clr   (int_clr),
      .int_en    (int_en),
      .cnt       (cnt),
      .cmp       (cmp),
      .int_st    (int_st),
      .tim_int   (tim_int)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Spec-level model: the counter is a 64-bit number; a write replaces the
   // strobed byte lanes of the addressed halves, expressed as a 64-bit mask.
   logic [63:0] m_cnt, m_cmp;
   logic        m_int_st, m_ten_d;

   function automatic logic [63:0] lane_mask(input logic lo, input logic hi, input logic [3:0] st);
      logic [63:0] m;
      m = '0;
      for (int b = 0; b < 4; b++) begin
         if (st[b] && lo) m = m | (64'hFF << (8 * b));
         if (st[b] && hi) m = m | (64'hFF << (8 * (b + 4)));
      end
      return m;
   endfunction

   always @(posedge clk) begin
      logic        matched;
      logic [63:0] mk;
      if (!rst_n) begin
         m_cnt    = 64'd0;
         m_cmp    = CMP_RST;
         m_int_st = 1'b0;
         m_ten_d  = 1'b0;
      end else begin
         matched = (m_cnt == m_cmp);
         if (cnt_lo_wr || cnt_hi_wr) begin
            mk    = lane_mask(cnt_lo_wr, cnt_hi_wr, wstrb);
            m_cnt = (m_cnt & ~mk) | ({wdata, wdata} & mk);
         end else if (m_ten_d && !timer_en) begin
            m_cnt = 64'd0;
         end else if (cnt_en) begin
            m_cnt = m_cnt + 64'd1;
         end
         mk    = lane_mask(cmp_lo_wr, cmp_hi_wr, wstrb);
         m_cmp = (m_cmp & ~mk) | ({wdata, wdata} & mk);
         if (matched)      m_int_st = 1'b1;
         else if (int_clr) m_int_st = 1'b0;
         m_ten_d = timer_en;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_cnt",     cnt,     m_cnt);
         check("model_cmp",     cmp,     m_cmp);
         check("model_int_st",  {63'd0, int_st},  {63'd0, m_int_st});
         check("model_tim_int", {63'd0, tim_int}, {63'd0, m_int_st & int_en});
      end
   end

   // Advance n rising edges; inputs change 1 time unit after the edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; timer_en = 1'b0; cnt_en = 1'b0; wdata = '0; wstrb = '0;
      cnt_lo_wr = 1'b0; cnt_hi_wr = 1'b0; cmp_lo_wr = 1'b0; cmp_hi_wr = 1'b0;
      int_clr = 1'b0; int_en = 1'b0;
      step(2);
      check("reset_cnt", cnt, 64'd0);
      check("reset_cmp", cmp, CMP_RST);
      check("reset_int_st", {63'd0, int_st}, 64'd0);
      check("reset_tim_int", {63'd0, tim_int}, 64'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Ten ticks from reset
      timer_en = 1'b1; cnt_en = 1'b1;
      step(10);
      cnt_en = 1'b0;
      check("count10", cnt, 64'd10);
      check("count10_int", {63'd0, int_st}, 64'd0);

      // Wrap through all-ones (matches the reset compare value)
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF; cnt_hi_wr = 1'b1;
      step(1);
      cnt_hi_wr = 1'b0; wdata = 32'hFFFF_FFFE; cnt_lo_wr = 1'b1;
      step(1);
      cnt_lo_wr = 1'b0;
      check("wrap_load", cnt, 64'hFFFF_FFFF_FFFF_FFFE);
      cnt_en = 1'b1;
      step(1);
      check("wrap_max", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
      check("wrap_max_int", {63'd0, int_st}, 64'd0);
      step(1);
      cnt_en = 1'b0;
      check("wrap_zero", cnt, 64'd0);
      check("wrap_int_set", {63'd0, int_st}, 64'd1);
      int_clr = 1'b1;
      step(1);
      int_clr = 1'b0;
      check("wrap_int_clr", {63'd0, int_st}, 64'd0);

      // Compare interrupt at cmp = 5
      wdata = 32'd0; cmp_hi_wr = 1'b1;
      step(1);
      cmp_hi_wr = 1'b0; wdata = 32'd5; cmp_lo_wr = 1'b1;
      step(1);
      cmp_lo_wr = 1'b0; int_en = 1'b1;
      check("cmp5", cmp, 64'd5);
      cnt_en = 1'b1;
      step(5);
      cnt_en = 1'b0;
      check("cmp_cnt5", cnt, 64'd5);
      check("cmp_pre_int", {63'd0, int_st}, 64'd0);
      step(1);
      check("cmp_int_st", {63'd0, int_st}, 64'd1);
      check("cmp_tim_int", {63'd0, tim_int}, 64'd1);
      int_en = 1'b0; #1;
      check("int_en_off_line", {63'd0, tim_int}, 64'd0);
      check("int_en_off_st", {63'd0, int_st}, 64'd1);
      int_en = 1'b1;
      int_clr = 1'b1;
      step(1);
      int_clr = 1'b0;
      check("clr_during_match", {63'd0, int_st}, 64'd1);
      cnt_en = 1'b1;
      step(1);
      cnt_en = 1'b0;
      check("cnt6", cnt, 64'd6);
      int_clr = 1'b1;
      step(1);
      int_clr = 1'b0;
      check("clr_after_match", {63'd0, int_st}, 64'd0);
      check("clr_after_line", {63'd0, tim_int}, 64'd0);

      // Priority: write beats tick, then write beats disable clear
      timer_en = 1'b0;
      step(1);
      check("disable_to_zero", cnt, 64'd0);
      timer_en = 1'b1;
      step(1);
      wdata = 32'h1234_5678; wstrb = 4'b0011; cnt_lo_wr = 1'b1; cnt_en = 1'b1;
      step(1);
      cnt_lo_wr = 1'b0; cnt_en = 1'b0;
      check("wr_beats_tick", cnt, 64'h0000_0000_0000_5678);
      wdata = 32'h0000_00AB; wstrb = 4'hF; cnt_lo_wr = 1'b1; timer_en = 1'b0;
      step(1);
      cnt_lo_wr = 1'b0;
      check("wr_beats_fall", cnt, 64'h0000_0000_0000_00AB);
      timer_en = 1'b1;
      step(1);
      check("rise_no_action", cnt, 64'h0000_0000_0000_00AB);

      // Disable clear after counting to 7
      wdata = 32'd0; cnt_lo_wr = 1'b1;
      step(1);
      cnt_lo_wr = 1'b0; cnt_en = 1'b1;
      step(7);
      cnt_en = 1'b0;
      check("count7", cnt, 64'd7);
      timer_en = 1'b0;
      step(1);
      check("fall_clear", cnt, 64'd0);
      step(3);
      check("fall_hold", cnt, 64'd0);

      // Mid-operation reset with cnt = cmp = 100 and status set
      timer_en = 1'b1; wdata = 32'd100; cnt_lo_wr = 1'b1; cmp_lo_wr = 1'b1;
      step(1);
      cnt_lo_wr = 1'b0; cmp_lo_wr = 1'b0;
      step(1);
      check("pre_rst_cnt", cnt, 64'd100);
      check("pre_rst_int", {63'd0, int_st}, 64'd1);
      rst_n = 1'b0; cnt_en = 1'b1; int_clr = 1'b0;
      step(1);
      rst_n = 1'b1; cnt_en = 1'b0;
      check("rst_cnt", cnt, 64'd0);
      check("rst_cmp", cmp, CMP_RST);
      check("rst_int_st", {63'd0, int_st}, 64'd0);
      check("rst_tim_int", {63'd0, tim_int}, 64'd0);
      step(3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
